core_csr_access_unit: RTL and testbench
=======================================

CORE_CSR_ACCESS_UNIT -- requirements
Module: core_csr_access_unit

Interface
REQ-001 SHALL have parameter CHECK_PRIV, default 1, meaning: 1 enables privilege/read-only legality checks, 0 treats every access as legal.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  CSR instruction request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_op  input  csr_op_e (2)  operation: RW, RS, RC.
REQ-007 SHALL have port req_csr_sel  input  12  target CSR address.
REQ-008 SHALL have port req_operand  input  word_t (32)  rs1 value or zero-extended immediate.
REQ-009 SHALL have port req_src_zero  input  1  source field (rs1 index or uimm) is zero.
REQ-010 SHALL have port priv_mode  input  priv_e (2)  current privilege level: U=0, S=1, M=3.
REQ-011 SHALL have port csr_sel  output  12  address driven to the CSR file.
REQ-012 SHALL have port csr_rdata  input  word_t  combinational read data from the CSR file for csr_sel.
REQ-013 SHALL have port csr_we  output  1  one-cycle write strobe to the CSR file.
REQ-014 SHALL have port csr_wdata  output  word_t  write data to the CSR file.
REQ-015 SHALL have port rsp_valid  output  1  response present.
REQ-016 SHALL have port rsp_ready  input  1  consumer accepts the response.
REQ-017 SHALL have port rsp_rdata  output  word_t  old CSR value, destined for rd.
REQ-018 SHALL have port rsp_illegal  output  1  access raises an illegal-instruction exception.

Function
REQ-019 SHALL implement FSM states IDLE, READ, WRITE and RESP.
REQ-020 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both 1, and the FSM then moves to READ.
REQ-021 SHALL register op, sel, operand and src_zero on accept and keep them stable until the FSM returns to IDLE.
REQ-022 SHALL drive csr_sel from the registered sel in READ and WRITE, and 0 otherwise.
REQ-023 SHALL in READ capture csr_rdata into rsp_rdata and compute the write value.
   - RW: operand.
   - RS: old OR operand.
   - RC: old AND NOT operand.
REQ-024 SHALL treat an access as a write when op is RW, or when op is RS/RC and src_zero is 0.
REQ-025 SHALL, when CHECK_PRIV is 1, flag an access illegal if sel[9:8] > priv_mode, or if sel[11:10] is 2'b11 and the access is a write.
REQ-026 SHALL move READ->WRITE for a legal write, and READ->RESP otherwise.
REQ-027 SHALL in WRITE assert csr_we for exactly one cycle with csr_wdata set to the computed value, then move to RESP.
REQ-028 SHALL never assert csr_we for an illegal access or a non-write access.
REQ-029 SHALL hold rsp_valid, rsp_rdata and rsp_illegal stable in RESP until rsp_ready is 1, then return to IDLE.
REQ-030 SHALL give rsp_rdata as 0 when rsp_illegal is 1.
REQ-031 SHALL have a latency from accept to rsp_valid of 3 cycles for a write and 2 cycles for a non-write or illegal access.
REQ-032 SHALL have a minimum request spacing of latency+1 cycles, because no request is accepted in RESP.
REQ-033 SHALL drive csr_wdata as 0 whenever csr_we is 0.

Reset
REQ-034 SHALL, when rst_n is low at a clock edge, enter IDLE and drive these values from the next cycle:
   - req_ready=1
   - rsp_valid=0
   - csr_we=0
   - csr_sel=0
   - csr_wdata=0
   - rsp_rdata=0
   - rsp_illegal=0
REQ-035 SHALL abort any in-flight transaction on a reset taken in READ, WRITE or RESP, with no csr_we issued after the reset edge.

Structure
REQ-036 SHALL take csr_op_e (RW=1, RS=2, RC=3, 0 reserved and treated as illegal) and priv_e from core_pkg.
REQ-037 SHALL be a single module with no sub-modules; the FSM state enum is local to the module.

Verification
REQ-038 SHALL cover: RW to 0x340 at priv=M, csr_rdata=0x1234, operand=0xAAAA0000 -> csr_we at accept+2 with wdata=0xAAAA0000, rsp_rdata=0x1234, rsp_valid at accept+3.
REQ-039 SHALL cover: RS to 0x300, old=0x8, operand=0x2, src_zero=1 -> no csr_we, rsp_rdata=0x8, rsp_valid at accept+2.
REQ-040 SHALL cover: RC to 0x300, old=0xFF, operand=0x0F -> csr_wdata=0xF0, one-cycle csr_we.
REQ-041 SHALL cover: RW to 0xF14 (read-only) at M -> rsp_illegal=1, rsp_rdata=0, no csr_we; RS to 0x300 at priv=U with src_zero=1 -> rsp_illegal=1.
REQ-042 SHALL cover: rsp_ready held 0 for 5 cycles -> response stable, req_ready=0 throughout; a new req_valid is accepted only in the cycle after the rsp handshake.
REQ-043 SHALL cover: rst_n low during WRITE -> csr_we=0 from the next cycle, FSM in IDLE, req_ready=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: CSR operation and privilege encodings, the CSR request
// payload, and the write-value rule for CSR instructions.
package core_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned CSR_ADDR_W = 12;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [CSR_ADDR_W-1:0] csr_addr_t;

    typedef enum logic [1:0] {
        CSR_OP_RSV = 2'd0,
        CSR_OP_RW  = 2'd1,
        CSR_OP_RS  = 2'd2,
        CSR_OP_RC  = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        PRIV_U = 2'd0,
        PRIV_S = 2'd1,
        PRIV_M = 2'd3
    } priv_e;

    typedef struct packed {
        csr_op_e   op;
        csr_addr_t sel;
        word_t     operand;
        logic      src_zero;
    } csr_req_t;

    // New CSR value from the old value and the instruction operand.
    function automatic word_t csr_write_value(csr_op_e op, word_t old_v, word_t operand);
        word_t res;
        case (op)
            CSR_OP_RW: res = operand;
            CSR_OP_RS: res = old_v | operand;
            CSR_OP_RC: res = old_v & ~operand;
            default:   res = old_v;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/core_csr_access_unit.sv
// Sequences one CSR instruction at a time: read old value, legality check,
// optional one-cycle write strobe, then hold the response until consumed.
module core_csr_access_unit
    import core_pkg::*;
#(
    parameter bit CHECK_PRIV = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  csr_op_e               req_op,
    input  logic [CSR_ADDR_W-1:0] req_csr_sel,
    input  word_t                 req_operand,
    input  logic                  req_src_zero,
    input  priv_e                 priv_mode,
    output logic [CSR_ADDR_W-1:0] csr_sel,
    input  word_t                 csr_rdata,
    output logic                  csr_we,
    output word_t                 csr_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output word_t                 rsp_rdata,
    output logic                  rsp_illegal
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]            state_q,       state_d;
    csr_req_t              req_q,         req_d;
    logic                  req_ready_q,   req_ready_d;
    logic [CSR_ADDR_W-1:0] csr_sel_q,     csr_sel_d;
    logic                  csr_we_q,      csr_we_d;
    word_t                 csr_wdata_q,   csr_wdata_d;
    logic                  rsp_valid_q,   rsp_valid_d;
    word_t                 rsp_rdata_q,   rsp_rdata_d;
    logic                  rsp_illegal_q, rsp_illegal_d;

    logic is_write_c;
    logic illegal_c;

    // RS/RC with a zero source field are pure reads; reserved op is always illegal.
    always_comb begin
        is_write_c = (req_q.op == CSR_OP_RW) ||
                     (((req_q.op == CSR_OP_RS) || (req_q.op == CSR_OP_RC)) && !req_q.src_zero);
        illegal_c  = (req_q.op == CSR_OP_RSV) ||
                     (CHECK_PRIV && ((req_q.sel[9:8] > 2'(priv_mode)) ||
                                     ((req_q.sel[11:10] == 2'b11) && is_write_c)));
    end

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        req_ready_d   = req_ready_q;
        csr_sel_d     = csr_sel_q;
        csr_we_d      = 1'b0;
        csr_wdata_d   = '0;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_illegal_d = rsp_illegal_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_d       = '{op: req_op, sel: req_csr_sel,
                                    operand: req_operand, src_zero: req_src_zero};
                    csr_sel_d   = req_csr_sel;
                    req_ready_d = 1'b0;
                    state_d     = ST_READ;
                end
            end
            ST_READ: begin
                rsp_illegal_d = illegal_c;
                rsp_rdata_d   = illegal_c ? '0 : csr_rdata;
                if (is_write_c && !illegal_c) begin
                    csr_we_d    = 1'b1;
                    csr_wdata_d = csr_write_value(req_q.op, csr_rdata, req_q.operand);
                    state_d     = ST_WRITE;
                end else begin
                    csr_sel_d   = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_WRITE: begin
                csr_sel_d   = '0;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    rsp_rdata_d   = '0;
                    rsp_illegal_d = 1'b0;
                    req_ready_d   = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                csr_sel_d   = '0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            req_q         <= '0;
            req_ready_q   <= 1'b1;
            csr_sel_q     <= '0;
            csr_we_q      <= 1'b0;
            csr_wdata_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            req_ready_q   <= req_ready_d;
            csr_sel_q     <= csr_sel_d;
            csr_we_q      <= csr_we_d;
            csr_wdata_q   <= csr_wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign csr_sel     = csr_sel_q;
    assign csr_we      = csr_we_q;
    assign csr_wdata   = csr_wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_core_csr_access_unit.sv
// Directed and randomized bench for core_csr_access_unit with a CSR-file
// model and a rule-level reference model of expected responses.
module tb_core_csr_access_unit;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    csr_op_e     req_op = CSR_OP_RSV;
    logic [11:0] req_csr_sel = '0;
    word_t       req_operand = '0;
    logic        req_src_zero = 1'b0;
    priv_e       priv_mode = PRIV_M;
    logic [11:0] csr_sel;
    word_t       csr_rdata;
    logic        csr_we;
    word_t       csr_wdata;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    word_t       rsp_rdata;
    logic        rsp_illegal;

    int checks = 0;
    int errors = 0;

    // CSR file model with a preload port for the bench
    logic [31:0] csr_mem [4096];
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_data = '0;

    logic [31:0] exp_rd, exp_wd;
    logic [11:0] exp_sel;
    int          exp_ill, exp_wr, exp_lat;

    always #5 clk = ~clk;

    assign csr_rdata = csr_mem[csr_sel];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4096; i++) csr_mem[i] <= '0;
        end else if (csr_we) begin
            csr_mem[csr_sel] <= csr_wdata;
        end else if (pre_en) begin
            csr_mem[pre_addr] <= pre_data;
        end
    end

    core_csr_access_unit #(.CHECK_PRIV(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_csr_sel  (req_csr_sel),
        .req_operand  (req_operand),
        .req_src_zero (req_src_zero),
        .priv_mode    (priv_mode),
        .csr_sel      (csr_sel),
        .csr_rdata    (csr_rdata),
        .csr_we       (csr_we),
        .csr_wdata    (csr_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_illegal  (rsp_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Reference model: expected outcome of one CSR instruction from the ISA rules.
    task automatic model(input int op, input int sel, input logic [31:0] opnd,
                         input int sz, input int pv, input logic [31:0] old);
        int wants_write, ill;
        wants_write = (op == 1) || ((op == 2 || op == 3) && sz == 0);
        ill = (op == 0) || (((sel >> 8) & 3) > pv) ||
              ((((sel >> 10) & 3) == 3) && wants_write != 0);
        exp_ill = ill;
        exp_wr  = (wants_write != 0 && ill == 0) ? 1 : 0;
        exp_lat = (exp_wr == 1) ? 3 : 2;
        exp_rd  = (ill != 0) ? 32'd0 : old;
        if (op == 1)      exp_wd = opnd;
        else if (op == 2) exp_wd = old | opnd;
        else              exp_wd = old & ~opnd;
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic start(input logic [1:0] op, input logic [11:0] sel, input logic [31:0] opnd,
                         input logic sz, input logic [1:0] pv);
        model(int'(op), int'(sel), opnd, int'(sz), int'(pv), csr_mem[sel]);
        exp_sel = sel;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_op = csr_op_e'(op); req_csr_sel = sel; req_operand = opnd;
        req_src_zero = sz; priv_mode = priv_e'(pv); req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; cycle k is k edges after accept.
    task automatic observe();
        int we_cnt, we_cyc, rsp_cyc;
        logic [31:0] we_d;
        logic [11:0] we_s;
        we_cnt = 0; we_cyc = 0; rsp_cyc = 0; we_d = '0; we_s = '0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (k == 1) check("sel_in_read", 32'(csr_sel), 32'(exp_sel));
            if (csr_we) begin
                we_cnt++; we_cyc = k; we_d = csr_wdata; we_s = csr_sel;
            end else begin
                check("wdata_zero_no_we", csr_wdata, 32'd0);
            end
            if (rsp_valid) begin rsp_cyc = k; break; end
        end
        check("rsp_latency", 32'(rsp_cyc), 32'(exp_lat));
        check("we_count", 32'(we_cnt), 32'(exp_wr));
        if (exp_wr == 1) begin
            check("we_cycle", 32'(we_cyc), 32'd2);
            check("wdata", we_d, exp_wd);
            check("we_sel", 32'(we_s), 32'(exp_sel));
        end
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_illegal", 32'(rsp_illegal), 32'(exp_ill));
        check("sel_in_resp", 32'(csr_sel), 32'd0);
    endtask

    task automatic respond(input int hold, input bit pend);
        rsp_ready = 1'b0;
        if (pend) req_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, exp_rd);
            check("hold_illegal", 32'(rsp_illegal), 32'(exp_ill));
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_no_we", 32'(csr_we), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_req_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic txn(input logic [1:0] op, input logic [11:0] sel, input logic [31:0] opnd,
                       input logic sz, input logic [1:0] pv, input int hold);
        start(op, sel, opnd, sz, pv);
        observe();
        respond(hold, 1'b0);
    endtask

    initial begin
        logic [11:0] sels [8];
        sels = '{12'h340, 12'h300, 12'hF14, 12'h100, 12'h000, 12'hC00, 12'h7C0, 12'h200};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_csr_we", 32'(csr_we), 32'd0);
        check("rst_csr_sel", 32'(csr_sel), 32'd0);
        check("rst_csr_wdata", csr_wdata, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // RW at M
        preload(12'h340, 32'h1234);
        txn(2'd1, 12'h340, 32'hAAAA_0000, 1'b0, 2'd3, 0);
        check("rw_mem", csr_mem[12'h340], 32'hAAAA_0000);

        // RS with zero source: read only
        preload(12'h300, 32'h8);
        txn(2'd2, 12'h300, 32'h2, 1'b1, 2'd3, 1);
        check("rs_mem_unchanged", csr_mem[12'h300], 32'h8);

        // RC clears bits
        preload(12'h300, 32'hFF);
        txn(2'd3, 12'h300, 32'h0F, 1'b0, 2'd3, 0);
        check("rc_mem", csr_mem[12'h300], 32'hF0);

        // Illegal: write to read-only, and M-level CSR from U
        preload(12'hF14, 32'hABCD);
        txn(2'd1, 12'hF14, 32'h5, 1'b0, 2'd3, 0);
        check("ro_mem_unchanged", csr_mem[12'hF14], 32'hABCD);
        txn(2'd2, 12'h300, 32'h0, 1'b1, 2'd0, 0);

        // Long backpressure with a pending request; accepted only after handshake
        preload(12'h340, 32'h5555);
        start(2'd1, 12'h340, 32'h1111, 1'b0, 2'd3);
        observe();
        respond(5, 1'b1);
        start(2'd2, 12'h340, 32'h0F00, 1'b0, 2'd3);
        observe();
        respond(0, 1'b0);
        check("pend_mem", csr_mem[12'h340], 32'h1F11);

        // Reset taken during WRITE
        start(2'd1, 12'h341, 32'h77, 1'b0, 2'd3);
        @(posedge clk); #1;
        check("pre_rst_we", 32'(csr_we), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rstw_csr_we", 32'(csr_we), 32'd0);
        check("rstw_req_ready", 32'(req_ready), 32'd1);
        check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstw_csr_sel", 32'(csr_sel), 32'd0);
        @(posedge clk); #1;
        check("rstw_csr_we2", 32'(csr_we), 32'd0);
        check("rstw_rsp_valid2", 32'(rsp_valid), 32'd0);
        txn(2'd1, 12'h340, 32'hCAFE, 1'b0, 2'd3, 0);

        // Randomized transactions
        for (int n = 0; n < 60; n++) begin
            logic [11:0] s;
            logic [1:0]  pv;
            int          pr;
            if ($urandom_range(0, 3) == 0) s = 12'($urandom);
            else s = sels[$urandom_range(0, 7)];
            pr = $urandom_range(0, 2);
            pv = (pr == 0) ? 2'd0 : (pr == 1) ? 2'd1 : 2'd3;
            if ($urandom_range(0, 1) == 1) preload(s, $urandom);
            txn(2'($urandom_range(0, 3)), s, $urandom, 1'($urandom_range(0, 1)), pv,
                $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
